// File: rtl/mips_pkg.sv
// mips_pkg: shared sequencer state encoding, reset PC, PC increment and field widths.
package mips_pkg;
    typedef enum logic [1:0] {BOOT, FETCH, REDIR_WAIT} state_t;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam int IMM_W = 16;
    localparam int JIDX_W = 26;
endpackage

// File: rtl/branch_target_gen.sv
// branch_target_gen: branch target (pc4 + sext(imm) << 2) and jump target ({pc4[31:28], idx, 2'b00}).
module branch_target_gen
    import mips_pkg::*;
(
    input  logic [31:0]       i_branch_pc4,
    input  logic [IMM_W-1:0]  i_branch_imm,
    input  logic [31:0]       i_jump_pc4,
    input  logic [JIDX_W-1:0] i_jump_idx,
    output logic [31:0]       o_branch_target,
    output logic [31:0]       o_jump_target
);
    assign o_branch_target = i_branch_pc4 + {{14{i_branch_imm[IMM_W-1]}}, i_branch_imm, 2'b00};
    assign o_jump_target = {i_jump_pc4[31:28], i_jump_idx, 2'b00};
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC owner, next-PC select, imem handshake and redirect flushes.
// Define PC_SEQ_DELAY_SLOT_EN to keep the architectural branch delay slot alive.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter int          PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            branch_ex,
    input  logic [PC_W-1:0] branch_pc4_ex,
    input  logic [15:0]     branch_imm_ex,
    input  logic            jump_id,
    input  logic [PC_W-1:0] jump_pc4_id,
    input  logic [25:0]     jump_idx_id,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc4,
    output logic            imem_req,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            redir_busy
);
    import mips_pkg::*;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_target;
    logic        r_imem_req;
    logic        r_redir_busy;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_target;
    logic        w_fetch;
    logic        w_br;
    logic        w_jp;
    logic        w_discard;

    branch_target_gen u_tgt (
        .i_branch_pc4    (branch_pc4_ex),
        .i_branch_imm    (branch_imm_ex),
        .i_jump_pc4      (jump_pc4_id),
        .i_jump_idx      (jump_idx_id),
        .o_branch_target (w_branch_target),
        .o_jump_target   (w_jump_target)
    );

    assign w_fetch   = r_state == FETCH;
    assign w_br      = w_fetch & branch_ex;
    assign w_jp      = w_fetch & jump_id & ~branch_ex;
    assign w_discard = (r_state == REDIR_WAIT) & imem_ready;
    assign w_target  = branch_ex ? w_branch_target : w_jump_target;

`ifdef PC_SEQ_DELAY_SLOT_EN
    assign flush_ifid = w_br | w_discard;
    assign flush_idex = 1'b0;
`else
    assign flush_ifid = w_br | w_jp | w_discard;
    assign flush_idex = w_br;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_pend_target <= '0;
            r_imem_req    <= 1'b0;
            r_redir_busy  <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state    <= FETCH;
                    r_imem_req <= 1'b1;
                end
                FETCH: begin
                    if (w_br | w_jp) begin
                        if (imem_ready) r_pc <= w_target;
                        else begin
                            r_pend_target <= w_target;
                            r_state       <= REDIR_WAIT;
                            r_redir_busy  <= 1'b1;
                        end
                    end else if (imem_ready && !stall) r_pc <= r_pc + PC_INC;
                end
                REDIR_WAIT: begin
                    if (imem_ready) begin
                        r_pc         <= r_pend_target;
                        r_state      <= FETCH;
                        r_redir_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= BOOT;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign pc         = r_pc;
    assign pc4        = r_pc + PC_INC;
    assign imem_req   = r_imem_req;
    assign redir_busy = r_redir_busy;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;
    logic        branch_ex = 1'b0;
    logic [31:0] branch_pc4_ex = '0;
    logic [15:0] branch_imm_ex = '0;
    logic        jump_id = 1'b0;
    logic [31:0] jump_pc4_id = '0;
    logic [25:0] jump_idx_id = '0;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        imem_req;
    logic        flush_ifid;
    logic        flush_idex;
    logic        redir_busy;
    int checks = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .branch_ex     (branch_ex),
        .branch_pc4_ex (branch_pc4_ex),
        .branch_imm_ex (branch_imm_ex),
        .jump_id       (jump_id),
        .jump_pc4_id   (jump_pc4_id),
        .jump_idx_id   (jump_idx_id),
        .pc            (pc),
        .pc4           (pc4),
        .imem_req      (imem_req),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .redir_busy    (redir_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc4, 32'h4);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_busy", {31'b0, redir_busy}, 32'h0);
        chk("rst_fifid", {31'b0, flush_ifid}, 32'h0);
        chk("rst_fidex", {31'b0, flush_idex}, 32'h0);
        reset = 1'b0;
        #1;
        chk("boot_req", {31'b0, imem_req}, 32'h0);
        tick();
        chk("fetch_req", {31'b0, imem_req}, 32'h1);
        chk("fetch_pc0", pc, 32'h0);
        imem_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", pc, 32'(i * 4));
        end
        stall = 1'b1;
        tick();
        chk("stall_pc1", pc, 32'd16);
        tick();
        chk("stall_pc2", pc, 32'd16);
        // Branch back by two words: 0x100 + (-2 << 2)
        stall = 1'b0;
        branch_ex = 1'b1;
        branch_pc4_ex = 32'h0000_0100;
        branch_imm_ex = 16'hFFFE;
        #1;
        chk("br_fifid", {31'b0, flush_ifid}, 32'h1);
`ifdef PC_SEQ_DELAY_SLOT_EN
        chk("br_fidex", {31'b0, flush_idex}, 32'h0);
`else
        chk("br_fidex", {31'b0, flush_idex}, 32'h1);
`endif
        tick();
        chk("br_pc", pc, 32'h0000_00F8);
        branch_ex = 1'b0;
        jump_id = 1'b1;
        jump_pc4_id = 32'hA000_0004;
        jump_idx_id = 26'h000_0010;
        stall = 1'b1;
        #1;
`ifdef PC_SEQ_DELAY_SLOT_EN
        chk("jp_fifid", {31'b0, flush_ifid}, 32'h0);
`else
        chk("jp_fifid", {31'b0, flush_ifid}, 32'h1);
`endif
        chk("jp_fidex", {31'b0, flush_idex}, 32'h0);
        tick();
        chk("jp_pc", pc, 32'hA000_0040);
        jump_id = 1'b0;
        stall = 1'b0;
        branch_ex = 1'b1;
        branch_pc4_ex = 32'h0000_0200;
        branch_imm_ex = 16'h0000;
        imem_ready = 1'b0;
        tick();
        chk("miss_busy", {31'b0, redir_busy}, 32'h1);
        chk("miss_pc", pc, 32'hA000_0040);
        chk("miss_req", {31'b0, imem_req}, 32'h1);
        branch_ex = 1'b0;
        tick();
        tick();
        chk("wait_pc", pc, 32'hA000_0040);
        chk("wait_fifid", {31'b0, flush_ifid}, 32'h0);
        imem_ready = 1'b1;
        #1;
        chk("disc_fifid", {31'b0, flush_ifid}, 32'h1);
        chk("disc_fidex", {31'b0, flush_idex}, 32'h0);
        tick();
        chk("redir_pc", pc, 32'h0000_0200);
        chk("redir_busy0", {31'b0, redir_busy}, 32'h0);
        branch_ex = 1'b1;
        branch_pc4_ex = 32'h0000_0300;
        branch_imm_ex = 16'h0004;
        jump_id = 1'b1;
        jump_pc4_id = 32'h0;
        jump_idx_id = 26'h20;
        #1;
        chk("sim_fifid", {31'b0, flush_ifid}, 32'h1);
`ifdef PC_SEQ_DELAY_SLOT_EN
        chk("sim_fidex", {31'b0, flush_idex}, 32'h0);
`else
        chk("sim_fidex", {31'b0, flush_idex}, 32'h1);
`endif
        tick();
        chk("sim_pc", pc, 32'h0000_0310);
        branch_ex = 1'b0;
        jump_pc4_id = 32'hF000_0000;
        jump_idx_id = 26'h3FF_FFFF;
        tick();
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4, 32'h0);
        jump_id = 1'b0;
        tick();
        chk("wrap_pc", pc, 32'h0);
        jump_id = 1'b1;
        jump_pc4_id = 32'h0;
        jump_idx_id = 26'h10;
        tick();
        chk("pre_rst_pc", pc, 32'h0000_0040);
        jump_id = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_req", {31'b0, imem_req}, 32'h0);
        tick();
        reset = 1'b0;
        branch_ex = 1'b1;
        #1;
        chk("boot_fifid", {31'b0, flush_ifid}, 32'h0);
        chk("boot_req2", {31'b0, imem_req}, 32'h0);
        tick();
        branch_ex = 1'b0;
        chk("boot_pc", pc, 32'h0);
        chk("boot_done_req", {31'b0, imem_req}, 32'h1);
        tick();
        chk("post_boot_pc", pc, 32'h4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
